// File: rtl/gate2_bist_if.sv
// gate2_bist_if -- signal bundle between the gate2_bist engine and its surroundings
//
// Purpose:
//   Groups the run-control, gate-stimulus, gate-response and result signals of the
//   2-input gate self-test engine.
//
// Modports:
//   master : the BIST engine (drives A/B and results; receives start and C)
//   slave  : the environment (run controller plus the gate under test)
//
// Signals:
//   start     : run request, sampled only while the engine is idle
//   C         : output of the gate under test
//   A, B      : gate inputs (A = MSB, B = LSB of the vector index)
//   busy      : run in progress
//   done      : one-cycle end-of-run pulse
//   pass      : run result, valid from done until the next accepted start
//   fail_mask : bit i set when vector i mismatched
//   err_valid : at least one mismatch captured this run
//   err_vec   : index of the first failing vector
interface gate2_bist_if;
    logic       start;
    logic       C;
    logic       A;
    logic       B;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic       err_valid;
    logic [1:0] err_vec;

    modport master (
        input  start,
        input  C,
        output A,
        output B,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output err_valid,
        output err_vec
    );

    modport slave (
        output start,
        output C,
        input  A,
        input  B,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  err_valid,
        input  err_vec
    );
endinterface : gate2_bist_if

// File: rtl/gate2_bist.sv
// gate2_bist -- built-in self-test engine for any 2-input combinational gate
//
// Purpose:
//   Walks the gate's A/B inputs through the four vectors 00,01,10,11. Each vector is
//   held for SETTLE cycles, C is compared against TRUTH[{A,B}] during a one-cycle
//   CHECK, then GAP idle cycles follow. After the last vector a one-cycle done pulse
//   is raised together with the final pass/fail result.
//
// Parameters:
//   TRUTH  : expected C per vector index {A,B}; bit i is the value for vector i
//   SETTLE : cycles a vector is held before C is sampled (1..255)
//   GAP    : idle cycles after each check before the next vector (0..255)
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gate2_bist_if.master (start, C in; A, B, busy, done, pass,
//           fail_mask, err_valid, err_vec out)
module gate2_bist #(
    parameter logic [3:0]  TRUTH  = 4'b1001,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned GAP    = 5
) (
    input logic          clk,
    input logic          rst_n,
    gate2_bist_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_t;

    // Reload values for the 8-bit down-counter; the phase ends on the edge where
    // the counter reads zero, so a load of N-1 gives a phase of exactly N cycles.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [7:0] GAP_LOAD    = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    state_t     state_q,     state_d;
    logic [1:0] vec_q,       vec_d;
    logic [7:0] cnt_q,       cnt_d;
    logic [1:0] ab_q,        ab_d;
    logic       pass_q,      pass_d;
    logic [3:0] fail_mask_q, fail_mask_d;
    logic       err_valid_q, err_valid_d;
    logic [1:0] err_vec_q,   err_vec_d;

    // Set when the current vector has finished (end of CHECK with no gap, or end
    // of GAP); the shared advance-or-finish logic below acts on it.
    logic       step_end;

    // NOTE: every signal assigned in this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        ab_d        = ab_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        err_valid_d = err_valid_q;
        err_vec_d   = err_vec_q;
        step_end    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ab_d = 2'b00;
                if (bus.start) begin
                    vec_d       = 2'd0;
                    ab_d        = 2'b00;
                    pass_d      = 1'b0;
                    fail_mask_d = 4'b0000;
                    err_valid_d = 1'b0;
                    err_vec_d   = 2'd0;
                    cnt_d       = SETTLE_LOAD;
                    state_d     = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_CHECK: begin
                if (bus.C != TRUTH[vec_q]) begin
                    fail_mask_d[vec_q] = 1'b1;
                    // Only the first failing vector of a run is reported in err_vec.
                    if (!err_valid_q) begin
                        err_vec_d   = vec_q;
                        err_valid_d = 1'b1;
                    end
                end
                if (GAP == 0) begin
                    step_end = 1'b1;
                end else begin
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    step_end = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (step_end) begin
            if (vec_q == 2'd3) begin
                // fail_mask_d already carries the result of the final CHECK, so
                // pass is valid during the done cycle itself.
                ab_d    = 2'b00;
                pass_d  = (fail_mask_d == 4'b0000);
                state_d = S_DONE;
            end else begin
                vec_d   = vec_q + 2'd1;
                ab_d    = vec_q + 2'd1;
                cnt_d   = SETTLE_LOAD;
                state_d = S_SETTLE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    // The design holds no memories; every register is reset so a mid-run reset
    // aborts cleanly and leaves no stale result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= 8'd0;
            ab_q        <= 2'b00;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'b0000;
            err_valid_q <= 1'b0;
            err_vec_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            ab_q        <= ab_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            err_valid_q <= err_valid_d;
            err_vec_q   <= err_vec_d;
        end
    end

    assign bus.A         = ab_q[1];
    assign bus.B         = ab_q[0];
    assign bus.busy      = (state_q == S_SETTLE) || (state_q == S_CHECK) || (state_q == S_GAP);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_vec   = err_vec_q;

endmodule : gate2_bist
